// File: rtl/intersection_ctrl.sv
// Two-approach intersection sequencer: main road A rests in green, side road B is served on a
// latched sensor request. One internal down-counter times every interval.
//
// state | meaning
// ------+-----------------------------------------------
// A_GRN | main road green, rests here until a request
// A_YEL | main road yellow
// AR_A  | all-red clearance after A
// B_GRN | side road green, fixed length
// B_YEL | side road yellow
// AR_B  | all-red clearance after B (reset state)
module intersection_ctrl #(
   parameter int TW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sense_b,
   input  logic [TW-1:0] g_time,
   input  logic [TW-1:0] y_time,
   input  logic [TW-1:0] ar_time,
   output logic [2:0]    light_a,
   output logic [2:0]    light_b,
   output logic          req_pending,
   output logic [5:0]    state_oh
);

   typedef enum logic [5:0] {
      A_GRN = 6'b000001,
      A_YEL = 6'b000010,
      AR_A  = 6'b000100,
      B_GRN = 6'b001000,
      B_YEL = 6'b010000,
      AR_B  = 6'b100000
   } state_t;

   localparam logic [2:0] LT_GRN = 3'b100;
   localparam logic [2:0] LT_YEL = 3'b010;
   localparam logic [2:0] LT_RED = 3'b001;

   // Held as a plain vector so any bit pattern, including illegal ones, can be represented.
   logic [5:0]    state;
   logic [5:0]    state_nx;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_nx;
   logic          req_q;
   logic          req_nx;
   logic          expired;
   logic          enter_b;

   assign expired = (timer == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= AR_B;
         timer <= '0;
         req_q <= 1'b0;
      end else begin
         state <= state_nx;
         timer <= timer_nx;
         req_q <= req_nx;
      end
   end

   always_comb begin
      state_nx = state;
      timer_nx = expired ? '0 : timer - 1'b1;
      enter_b  = 1'b0;
      light_a  = LT_RED;
      light_b  = LT_RED;
      case (state)
         A_GRN: begin
            light_a = LT_GRN;
            if (expired && req_q) begin
               state_nx = A_YEL;
               timer_nx = y_time;
            end
         end
         A_YEL: begin
            light_a = LT_YEL;
            if (expired) begin
               state_nx = AR_A;
               timer_nx = ar_time;
            end
         end
         AR_A: begin
            if (expired) begin
               state_nx = B_GRN;
               timer_nx = g_time;
               enter_b  = 1'b1;
            end
         end
         B_GRN: begin
            light_b = LT_GRN;
            if (expired) begin
               state_nx = B_YEL;
               timer_nx = y_time;
            end
         end
         B_YEL: begin
            light_b = LT_YEL;
            if (expired) begin
               state_nx = AR_B;
               timer_nx = ar_time;
            end
         end
         AR_B: begin
            if (expired) begin
               state_nx = A_GRN;
               timer_nx = g_time;
            end
         end
         default: begin
            // Corrupted state: both groups stay red and recover through a full clearance.
            state_nx = AR_B;
            timer_nx = ar_time;
         end
      endcase
   end

   // Entering B_GRN serves the request; clearing wins over a coincident sensor hit.
   assign req_nx      = enter_b ? 1'b0 : (req_q | sense_b);
   assign req_pending = req_q;
   assign state_oh    = state;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Bench for intersection_ctrl: directed scenarios plus randomized traffic against a
// phase/elapsed-cycle reference model.
module tb_intersection_ctrl;

   localparam int TW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          sense_b = 1'b0;
   logic [TW-1:0] g_time = 16'd3;
   logic [TW-1:0] y_time = 16'd1;
   logic [TW-1:0] ar_time = 16'd0;
   logic [2:0]    light_a;
   logic [2:0]    light_b;
   logic          req_pending;
   logic [5:0]    state_oh;

   int n_cmp = 0;
   int n_bad = 0;
   bit mon_en = 1'b0;

   // reference model: phase 0..5 = A_GRN,A_YEL,AR_A,B_GRN,B_YEL,AR_B
   int m_ph;
   int m_el;
   int m_t;
   bit m_latch;

   intersection_ctrl #(.TW(TW)) dut (
      .clk(clk), .rst(rst), .sense_b(sense_b),
      .g_time(g_time), .y_time(y_time), .ar_time(ar_time),
      .light_a(light_a), .light_b(light_b),
      .req_pending(req_pending), .state_oh(state_oh)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         n_cmp++;
         if (light_a !== 3'b001 && light_b !== 3'b001) begin
            n_bad++;
            $display("FAIL safety: light_a=%b light_b=%b both non-red", light_a, light_b);
         end
      end
   end

   function automatic int interval(input int ph);
      case (ph)
         0, 3:    return int'(g_time);
         1, 4:    return int'(y_time);
         default: return int'(ar_time);
      endcase
   endfunction

   function automatic logic [5:0] exp_lights(input int ph);
      case (ph)
         0:       return {3'b100, 3'b001};
         1:       return {3'b010, 3'b001};
         3:       return {3'b001, 3'b100};
         4:       return {3'b001, 3'b010};
         default: return {3'b001, 3'b001};
      endcase
   endfunction

   task automatic model_reset();
      m_ph = 5; m_el = 0; m_t = 0; m_latch = 1'b0;
   endtask

   task automatic model_step(input logic s);
      bit adv;
      adv = (m_el >= m_t) && (m_ph != 0 || m_latch);
      m_latch = (m_ph == 2 && adv) ? 1'b0 : (m_latch | s);
      if (adv) begin
         m_ph = (m_ph + 1) % 6;
         m_el = 0;
         m_t  = interval(m_ph);
      end else begin
         m_el++;
      end
   endtask

   task automatic compare_model(input string tag);
      logic [5:0] el;
      logic [5:0] eoh;
      el  = exp_lights(m_ph);
      eoh = 6'(1 << m_ph);
      n_cmp++;
      if (state_oh !== eoh || {light_a, light_b} !== el || req_pending !== m_latch) begin
         n_bad++;
         $display("FAIL %s: state_oh=%b light_a=%b light_b=%b req=%b, required %b %b %b %b",
                  tag, state_oh, light_a, light_b, req_pending, eoh, el[5:3], el[2:0], m_latch);
      end
   endtask

   task automatic cycle(input logic s, input string tag);
      sense_b = s;
      @(posedge clk);
      model_step(s);
      #1;
      compare_model(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sense_b = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (light_a !== 3'b001 || light_b !== 3'b001 || req_pending !== 1'b0 || state_oh !== 6'b100000) begin
         n_bad++;
         $display("FAIL reset_values: %b %b %b %b, required 001 001 0 100000",
                  light_a, light_b, req_pending, state_oh);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      mon_en = 1'b1;
   endtask

   task automatic test_idle();
      g_time = 3; y_time = 1; ar_time = 0;
      do_reset();
      for (int i = 0; i < 55; i++) cycle(1'b0, "idle");
      n_cmp++;
      if (state_oh !== 6'b000001 || light_a !== 3'b100 || req_pending !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_rest: state_oh=%b light_a=%b req=%b, required 000001 100 0",
                  state_oh, light_a, req_pending);
      end
   endtask

   task automatic test_full_cycle();
      int exp_ph [1:15] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 4, 4, 5, 0};
      g_time = 3; y_time = 1; ar_time = 0;
      do_reset();
      for (int c = 1; c <= 15; c++) begin
         cycle(c == 1, "full_model");
         n_cmp++;
         if (state_oh !== 6'(1 << exp_ph[c]) || req_pending !== (c <= 7)) begin
            n_bad++;
            $display("FAIL full_cycle c%0d: state_oh=%b req=%b, required %b %b",
                     c, state_oh, req_pending, 6'(1 << exp_ph[c]), c <= 7);
         end
      end
   endtask

   task automatic test_late_request();
      g_time = 3; y_time = 1; ar_time = 0;
      do_reset();
      for (int i = 0; i < 10; i++) cycle(1'b0, "late_wait");
      cycle(1'b1, "late_pulse");
      n_cmp++;
      if (state_oh !== 6'b000001 || req_pending !== 1'b1) begin
         n_bad++;
         $display("FAIL late_latch: state_oh=%b req=%b, required 000001 1", state_oh, req_pending);
      end
      cycle(1'b0, "late_yel");
      n_cmp++;
      if (state_oh !== 6'b000010) begin
         n_bad++;
         $display("FAIL late_yellow: state_oh=%b, required 000010", state_oh);
      end
   endtask

   task automatic test_rerequest();
      int n;
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         cycle(1'b1, "rereq_wait_b");
         if (state_oh === 6'b001000) seen = 1'b1;
      end
      n_cmp++;
      if (!seen || req_pending !== 1'b0) begin
         n_bad++;
         $display("FAIL rereq_clear: seen_b_grn=%0d req=%b, required 1 0", seen, req_pending);
      end
      cycle(1'b1, "rereq_set");
      n_cmp++;
      if (req_pending !== 1'b1) begin
         n_bad++;
         $display("FAIL rereq_set: req=%b, required 1", req_pending);
      end
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         cycle(1'b1, "rereq_wait_a");
         if (state_oh === 6'b000001) seen = 1'b1;
      end
      n = 0;
      for (int i = 0; i < 50 && state_oh === 6'b000001; i++) begin
         n++;
         cycle(1'b0, "rereq_a_grn");
      end
      n_cmp++;
      if (!seen || n != int'(g_time) + 1 || state_oh !== 6'b000010) begin
         n_bad++;
         $display("FAIL rereq_a_len: a_grn cycles=%0d state_oh=%b, required %0d 000010",
                  n, state_oh, int'(g_time) + 1);
      end
   endtask

   task automatic test_zero_times();
      g_time = 0; y_time = 0; ar_time = 0;
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         cycle(1'b1, "zero_model");
         n_cmp++;
         if (state_oh !== 6'(1 << ((k - 1) % 6))) begin
            n_bad++;
            $display("FAIL zero_rotation k%0d: state_oh=%b, required %b",
                     k, state_oh, 6'(1 << ((k - 1) % 6)));
         end
      end
   endtask

   task automatic test_random();
      g_time = 16'($urandom_range(0, 4));
      y_time = 16'($urandom_range(0, 4));
      ar_time = 16'($urandom_range(0, 4));
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            g_time = 16'($urandom_range(0, 5));
            y_time = 16'($urandom_range(0, 5));
            ar_time = 16'($urandom_range(0, 5));
         end
         cycle($urandom_range(0, 3) == 0, "random");
      end
   endtask

   task automatic test_async_reset();
      bit seen;
      g_time = 3; y_time = 1; ar_time = 0;
      do_reset();
      cycle(1'b1, "async_req");
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cycle(1'b1, "async_wait");
         if (state_oh === 6'b001000) seen = 1'b1;
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (!seen || light_a !== 3'b001 || light_b !== 3'b001 || req_pending !== 1'b0
          || state_oh !== 6'b100000) begin
         n_bad++;
         $display("FAIL async_reset: seen=%0d %b %b %b %b, required 1 001 001 0 100000",
                  seen, light_a, light_b, req_pending, state_oh);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      cycle(1'b0, "post_reset");
      force dut.state = 6'b000101;
      #1;
      n_cmp++;
      if (state_oh !== 6'b000101 || light_a !== 3'b001 || light_b !== 3'b001) begin
         n_bad++;
         $display("FAIL illegal_decode: %b %b %b, required 000101 001 001",
                  state_oh, light_a, light_b);
      end
      release dut.state;
      ar_time = 2;
      sense_b = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (state_oh !== 6'b100000) begin
         n_bad++;
         $display("FAIL illegal_recover: state_oh=%b, required 100000", state_oh);
      end
      m_ph = 5; m_el = 0; m_t = 2;
      for (int i = 0; i < 6; i++) cycle(1'b0, "illegal_after");
   endtask

   initial begin
      test_reset();
      test_idle();
      test_full_cycle();
      test_late_request();
      test_rerequest();
      test_zero_times();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule
